// File: rtl/miner_pkg.sv
// Shared definitions for the work dispatcher: control state encoding and
// the fixed word and bit widths of one mining job.
package miner_pkg;

    localparam int WORD_W    = 32;
    localparam int MID_BITS  = 256;
    localparam int HEAD_BITS = 512;

    typedef enum logic [2:0] {
        IDLE,
        START,
        MID,
        HEAD,
        SOLVE,
        REPORT
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Load-and-shift register that emits N_WORDS words, first word from the MSB end,
// one beat every GAP+1 cycles while run is high; the last word is held during gaps.
module word_serializer #(
    parameter int WORD_W  = 32,
    parameter int N_WORDS = 24,
    parameter int GAP     = 0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         load,
    input  logic [WORD_W*N_WORDS-1:0]    data,
    input  logic                         run,
    output logic                         beat,
    output logic [$clog2(N_WORDS+1)-1:0] beat_idx,
    output logic [WORD_W-1:0]            word
);

    localparam int IDX_W = $clog2(N_WORDS + 1);
    localparam int CNT_W = $clog2(GAP + 2);

    logic [WORD_W-1:0] words_reg [N_WORDS];
    logic [WORD_W-1:0] shift_src [N_WORDS];
    logic [WORD_W-1:0] hold_reg;
    logic [CNT_W-1:0]  gap_reg;
    logic [IDX_W-1:0]  idx_reg;

    assign beat     = run && (gap_reg == '0);
    assign beat_idx = idx_reg;
    assign word     = beat ? words_reg[0] : hold_reg;

    // words_reg[0] always holds the next word to go out; each beat moves the
    // whole chain down one slot and backfills the tail with zero.
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_word
        if (gi < N_WORDS - 1) begin : g_link
            assign shift_src[gi] = words_reg[gi+1];
        end else begin : g_tail
            assign shift_src[gi] = '0;
        end

        always_ff @(posedge clk) begin
            if (!n_rst) begin
                words_reg[gi] <= '0;
            end else if (load) begin
                words_reg[gi] <= data[WORD_W*(N_WORDS-gi)-1 -: WORD_W];
            end else if (beat) begin
                words_reg[gi] <= shift_src[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || load) begin
            gap_reg  <= '0;
            idx_reg  <= '0;
            hold_reg <= '0;
        end else if (run) begin
            if (beat) begin
                gap_reg  <= CNT_W'(GAP);
                idx_reg  <= idx_reg + IDX_W'(1);
                hold_reg <= words_reg[0];
            end else begin
                gap_reg  <= gap_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/work_dispatcher.sv
// Host-side job transmitter: streams midstate and header words into the core,
// waits for a claimed solution (or timeout/abort) and hands the nonce back.
module work_dispatcher
    import miner_pkg::*;
#(
    parameter int MID_WORDS  = 8,
    parameter int HEAD_WORDS = 16,
    parameter int SHIFT_GAP  = 0,
    parameter int TIMEOUT_W  = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [MID_BITS-1:0]  job_midstate,
    input  logic [HEAD_BITS-1:0] job_header,
    input  logic [TIMEOUT_W-1:0] job_timeout,
    input  logic                 abort,
    output logic                 start_found,
    output logic                 shift_in_enable,
    output logic [WORD_W-1:0]    in_data,
    input  logic                 sol_claim,
    input  logic [WORD_W-1:0]    out_data,
    output logic                 sol_response,
    output logic                 nonce_valid,
    input  logic                 nonce_ready,
    output logic [WORD_W-1:0]    nonce,
    output logic                 job_expired,
    output logic                 busy
);

    localparam int N_WORDS = MID_WORDS + HEAD_WORDS;
    localparam int IDX_W   = $clog2(N_WORDS + 1);

    state_t               state_reg, state_next;
    logic                 ready_reg;
    logic [TIMEOUT_W-1:0] timeout_reg;
    logic [TIMEOUT_W-1:0] tcount_reg;
    logic [WORD_W-1:0]    nonce_reg;
    logic                 resp_reg;
    logic                 expired_reg;

    logic                 accept;
    logic                 shifting;
    logic                 expire;
    logic                 claim_take;
    logic                 ser_beat;
    logic [IDX_W-1:0]     ser_idx;
    logic [WORD_W-1:0]    ser_word;
    logic                 mid_last;
    logic                 head_last;

    assign accept    = job_valid && job_ready;
    assign shifting  = (state_reg == MID) || (state_reg == HEAD);
    assign mid_last  = ser_beat && (ser_idx == IDX_W'(MID_WORDS - 1));
    assign head_last = ser_beat && (ser_idx == IDX_W'(N_WORDS - 1));

    // One serializer over the concatenation keeps the gap pacing continuous
    // across the midstate/header boundary.
    word_serializer #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS),
        .GAP     (SHIFT_GAP)
    ) u_serializer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (accept),
        .data     ({job_midstate, job_header}),
        .run      (shifting),
        .beat     (ser_beat),
        .beat_idx (ser_idx),
        .word     (ser_word)
    );

    always_comb begin
        state_next = state_reg;
        expire     = 1'b0;
        claim_take = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                if (abort) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end else begin
                    state_next = MID;
                end
            end
            MID: begin
                if (abort) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end else if (mid_last) begin
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (abort) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end else if (head_last) begin
                    state_next = SOLVE;
                end
            end
            SOLVE: begin
                // Abort beats a claim, and a claim beats the timeout.
                if (abort) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end else if (sol_claim) begin
                    state_next = REPORT;
                    claim_take = 1'b1;
                end else if (tcount_reg == TIMEOUT_W'(1)) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end
            end
            REPORT: begin
                if (nonce_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b0;
            timeout_reg <= '0;
            tcount_reg  <= '0;
            nonce_reg   <= '0;
            resp_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ready_reg   <= 1'b1;
            resp_reg    <= claim_take;
            expired_reg <= expire;
            if (accept) timeout_reg <= job_timeout;
            // A zero limit loads zero and never reaches the expiry value of one.
            if (state_reg == HEAD && state_next == SOLVE) begin
                tcount_reg <= timeout_reg;
            end else if (state_reg == SOLVE && tcount_reg != '0) begin
                tcount_reg <= tcount_reg - TIMEOUT_W'(1);
            end
            if (claim_take) nonce_reg <= out_data;
        end
    end

    // ready_reg keeps job_ready low for the first cycle after reset.
    assign job_ready       = (state_reg == IDLE) && ready_reg;
    assign start_found     = (state_reg == START);
    assign shift_in_enable = ser_beat;
    assign in_data         = shifting ? ser_word : '0;
    assign sol_response    = resp_reg;
    assign nonce_valid     = (state_reg == REPORT);
    assign nonce           = nonce_reg;
    assign job_expired     = expired_reg;
    assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_work_dispatcher.sv
// Bench for work_dispatcher: two instances (SHIFT_GAP 0 and 2) share stimulus and are
// compared every cycle against a phase/elapsed-cycle model, plus literal checks.
module tb_work_dispatcher;

    localparam int NW = 24;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_SOLVE = 2, PH_REPORT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst, job_valid, abort, sol_claim, nonce_ready;
    logic [255:0] job_midstate;
    logic [511:0] job_header;
    logic [31:0]  job_timeout, out_data;

    logic        job_ready [2], start_found [2], shift_in_enable [2];
    logic        sol_response [2], nonce_valid [2], job_expired [2], busy [2];
    logic [31:0] in_data [2], nonce [2];

    int tests = 0;
    int fails = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        work_dispatcher #(
            .MID_WORDS  (8),
            .HEAD_WORDS (16),
            .SHIFT_GAP  (gi * 2),
            .TIMEOUT_W  (32)
        ) u_dut (
            .clk             (clk),
            .n_rst           (n_rst),
            .job_valid       (job_valid),
            .job_ready       (job_ready[gi]),
            .job_midstate    (job_midstate),
            .job_header      (job_header),
            .job_timeout     (job_timeout),
            .abort           (abort),
            .start_found     (start_found[gi]),
            .shift_in_enable (shift_in_enable[gi]),
            .in_data         (in_data[gi]),
            .sol_claim       (sol_claim),
            .out_data        (out_data),
            .sol_response    (sol_response[gi]),
            .nonce_valid     (nonce_valid[gi]),
            .nonce_ready     (nonce_ready),
            .nonce           (nonce[gi]),
            .job_expired     (job_expired[gi]),
            .busy            (busy[gi])
        );
    end

    // Model: phase, cycles since accept (k), cycles spent solving (s).
    int          m_ph [2];
    int          m_k [2];
    int          m_s [2];
    logic        m_rdy [2];
    logic [31:0] m_tmo [2];
    logic [31:0] m_nonce [2];
    logic        m_exp [2];
    logic        m_resp [2];
    logic [31:0] m_w [2][NW];

    function automatic logic [31:0] job_word(input int w);
        if (w < 8) return job_midstate[255-32*w -: 32];
        return job_header[511-32*(w-8) -: 32];
    endfunction

    function automatic int last_k(input int i);
        return 2 + (NW - 1) * (2 * i + 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_exp[i]  <= 1'b0;
            m_resp[i] <= 1'b0;
            if (!n_rst) begin
                m_ph[i]    <= PH_IDLE;
                m_rdy[i]   <= 1'b0;
                m_nonce[i] <= '0;
            end else begin
                m_rdy[i] <= 1'b1;
                case (m_ph[i])
                    PH_IDLE: if (job_valid && m_rdy[i]) begin
                        m_ph[i]  <= PH_RUN;
                        m_k[i]   <= 1;
                        m_tmo[i] <= job_timeout;
                        for (int w = 0; w < NW; w++) m_w[i][w] <= job_word(w);
                    end
                    PH_RUN: if (abort) begin
                        m_ph[i]  <= PH_IDLE;
                        m_exp[i] <= 1'b1;
                    end else if (m_k[i] == last_k(i)) begin
                        m_ph[i] <= PH_SOLVE;
                        m_s[i]  <= 0;
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                    PH_SOLVE: if (abort) begin
                        m_ph[i]  <= PH_IDLE;
                        m_exp[i] <= 1'b1;
                    end else if (sol_claim) begin
                        m_ph[i]    <= PH_REPORT;
                        m_nonce[i] <= out_data;
                        m_resp[i]  <= 1'b1;
                    end else if (m_tmo[i] != 0 && m_s[i] == int'(m_tmo[i]) - 1) begin
                        m_ph[i]  <= PH_IDLE;
                        m_exp[i] <= 1'b1;
                    end else begin
                        m_s[i] <= m_s[i] + 1;
                    end
                    PH_REPORT: if (nonce_ready) m_ph[i] <= PH_IDLE;
                    default: m_ph[i] <= PH_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [70:0] exp_v, act_v;
            logic        e_en;
            logic [31:0] e_data;
            int          j;
            e_en   = 1'b0;
            e_data = '0;
            if (m_ph[i] == PH_RUN && m_k[i] >= 2) begin
                j      = m_k[i] - 2;
                e_en   = (j % (2 * i + 1)) == 0;
                e_data = m_w[i][j / (2 * i + 1)];
            end
            exp_v = {m_ph[i] != PH_IDLE, m_ph[i] == PH_IDLE && m_rdy[i],
                     m_ph[i] == PH_RUN && m_k[i] == 1, e_en, m_resp[i],
                     m_ph[i] == PH_REPORT, m_exp[i], e_data, m_nonce[i]};
            act_v = {busy[i], job_ready[i], start_found[i], shift_in_enable[i],
                     sol_response[i], nonce_valid[i], job_expired[i], in_data[i], nonce[i]};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL model_cmp inst%0d t=%0t got %h want %h (busy,rdy,start,en,resp,valid,exp,data,nonce)",
                         i, $time, act_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic load_job(input logic [31:0] mbase, input logic [31:0] hbase, input logic [31:0] tmo);
        for (int k = 0; k < 8; k++) job_midstate[255-32*k -: 32] = mbase + 32'(k);
        for (int k = 0; k < 16; k++) job_header[511-32*k -: 32] = hbase + 32'(k);
        job_timeout = tmo;
    endtask

    function automatic logic [31:0] lit_word(input int b);
        return (b < 8) ? 32'(b + 1) : 32'h1000_0000 + 32'(b - 8);
    endfunction

    task automatic accept_job();
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic resync();
        abort = 1'b1;
        nonce_ready = 1'b1;
        tick();
        abort = 1'b0;
        nonce_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_rst = 1'b0; job_valid = 1'b0; abort = 1'b0; sol_claim = 1'b0;
        nonce_ready = 1'b0; out_data = '0; job_timeout = '0;
        job_midstate = '0; job_header = '0;
        tick(); tick();
        chk1("rst_busy", busy[0], 1'b0);
        chk1("rst_ready", job_ready[0], 1'b0);
        chk32("rst_nonce", nonce[0], 32'h0);
        n_rst = 1'b1;
        tick();
        chk1("ready_after_rst", job_ready[0], 1'b1);

        // Basic job, gapless instance.
        load_job(32'h1, 32'h1000_0000, 32'd0);
        accept_job();
        chk1("start_found", start_found[0], 1'b1);
        chk1("start_busy", busy[0], 1'b1);
        for (int b = 0; b < NW; b++) begin
            tick();
            chk1("beat_en", shift_in_enable[0], 1'b1);
            chk32("beat_data", in_data[0], lit_word(b));
            chk1("beat_busy", busy[0], 1'b1);
        end
        tick();
        chk1("solve_en", shift_in_enable[0], 1'b0);
        chk32("solve_data", in_data[0], 32'h0);

        // Solution and held report.
        sol_claim = 1'b1; out_data = 32'hDEAD_BEEF;
        tick();
        sol_claim = 1'b0; out_data = '0;
        chk1("sol_response", sol_response[0], 1'b1);
        chk1("nonce_valid", nonce_valid[0], 1'b1);
        chk32("nonce", nonce[0], 32'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk1("resp_once", sol_response[0], 1'b0);
            chk1("valid_held", nonce_valid[0], 1'b1);
            chk32("nonce_held", nonce[0], 32'hDEAD_BEEF);
            chk1("ready_in_report", job_ready[0], 1'b0);
        end
        nonce_ready = 1'b1;
        tick();
        nonce_ready = 1'b0;
        chk1("report_done_valid", nonce_valid[0], 1'b0);
        chk1("report_done_ready", job_ready[0], 1'b1);
        resync();

        // Timeout on inst0 and paced shifting on inst1, c counts cycles after accept.
        load_job(32'h1, 32'h1000_0000, 32'd10);
        accept_job();
        for (int c = 1; c <= 85; c++) begin
            logic e1;
            if (c > 1) tick();
            chk1("g0_en", shift_in_enable[0], c >= 2 && c <= 25);
            chk1("g0_expired", job_expired[0], c == 36);
            chk1("g0_busy", busy[0], c <= 35);
            chk1("g0_valid", nonce_valid[0], 1'b0);
            e1 = c >= 2 && c <= 71 && ((c - 2) % 3) == 0;
            chk1("g2_en", shift_in_enable[1], e1);
            chk32("g2_data", in_data[1], (c >= 2 && c <= 71) ? lit_word((c - 2) / 3) : 32'h0);
            chk1("g2_expired", job_expired[1], c == 82);
        end
        chk1("timeout_ready", job_ready[0], 1'b1);

        // Abort on the 4th midstate beat.
        accept_job();
        for (int c = 2; c <= 5; c++) tick();
        chk32("beat4_data", in_data[0], 32'h4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_busy", busy[0], 1'b0);
        chk1("abort_expired", job_expired[0], 1'b1);
        chk1("abort_en", shift_in_enable[0], 1'b0);
        for (int c = 0; c < 30; c++) begin
            tick();
            chk1("abort_quiet", shift_in_enable[0] | shift_in_enable[1], 1'b0);
        end

        // Claim together with abort in SOLVE.
        load_job(32'h1, 32'h1000_0000, 32'd0);
        accept_job();
        for (int c = 2; c <= 26; c++) tick();
        sol_claim = 1'b1; abort = 1'b1; out_data = 32'h55AA_55AA;
        tick();
        sol_claim = 1'b0; abort = 1'b0; out_data = '0;
        chk1("claim_abort_resp", sol_response[0], 1'b0);
        chk1("claim_abort_exp", job_expired[0], 1'b1);
        chk1("claim_abort_valid", nonce_valid[0], 1'b0);
        tick();

        // Claim on the expiry cycle.
        load_job(32'h1, 32'h1000_0000, 32'd10);
        accept_job();
        for (int c = 2; c <= 35; c++) tick();
        sol_claim = 1'b1; out_data = 32'hCAFE_F00D;
        tick();
        sol_claim = 1'b0; out_data = '0;
        chk1("edge_claim_resp", sol_response[0], 1'b1);
        chk1("edge_claim_exp", job_expired[0], 1'b0);
        chk32("edge_claim_nonce", nonce[0], 32'hCAFE_F00D);
        resync();

        // Reset in SOLVE, then a clean job.
        load_job(32'h1, 32'h1000_0000, 32'd0);
        accept_job();
        for (int c = 2; c <= 27; c++) tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk1("rst_solve_busy", busy[0], 1'b0);
        chk1("rst_solve_exp", job_expired[0], 1'b0);
        chk1("rst_solve_ready", job_ready[0], 1'b0);
        chk32("rst_solve_nonce", nonce[0], 32'h0);
        tick();
        chk1("rst_solve_ready2", job_ready[0], 1'b1);
        load_job(32'hA000_0000, 32'hB000_0000, 32'd0);
        accept_job();
        for (int c = 2; c <= 26; c++) tick();
        sol_claim = 1'b1; out_data = 32'h1234_5678;
        tick();
        sol_claim = 1'b0; out_data = '0;
        chk1("post_rst_resp", sol_response[0], 1'b1);
        chk32("post_rst_nonce", nonce[0], 32'h1234_5678);
        nonce_ready = 1'b1;
        tick();
        nonce_ready = 1'b0;
        chk1("post_rst_idle", busy[0], 1'b0);
        resync();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
